// File: rtl/serializer_with_counter.sv
// serializer_with_counter: frames a stream of parallel words onto a serial line.
// A frame is one start bit and then DATA_LENGTH data bits, sent LSB first.
// Each word is WORD_SIZE bits wide. RCO asks the source for the next word one
// cycle before that word is needed. The final word may be truncated.
module serializer_with_counter #(
  parameter int unsigned DATA_LENGTH = 16,
  parameter int unsigned WORD_SIZE   = 8,
  parameter logic        START_BIT   = 1'b0,
  parameter logic        IDLE_BIT    = 1'b1
) (
  input  logic                 clock,
  input  logic                 reset,
  input  logic                 start,
  input  logic [WORD_SIZE-1:0] data_in,
  output logic                 data_out,
  output logic                 busy,
  output logic                 RCO,
  output logic                 done
);

  // Counter widths are kept at least one bit, so that degenerate parameters still elaborate.
  localparam int unsigned BIT_W = (WORD_SIZE > 1) ? $clog2(WORD_SIZE) : 1;
  localparam int unsigned CNT_W = (DATA_LENGTH > 1) ? $clog2(DATA_LENGTH) : 1;

  localparam logic [BIT_W-1:0] BIT_LAST = BIT_W'(WORD_SIZE - 1);
  localparam logic [BIT_W-1:0] BIT_ONE  = BIT_W'(1);
  localparam logic [BIT_W-1:0] BIT_ZERO = {BIT_W{1'b0}};
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DATA_LENGTH - 1);
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);
  localparam logic [CNT_W-1:0] CNT_ZERO = {CNT_W{1'b0}};

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_START = 2'd1,
    ST_DATA  = 2'd2
  } state_t;

  state_t               state_q, state_d;
  logic [WORD_SIZE-1:0] shreg_q, shreg_d;
  logic [BIT_W-1:0]     bit_cnt_q, bit_cnt_d;
  logic [CNT_W-1:0]     data_cnt_q, data_cnt_d;
  logic                 data_out_q, data_out_d;
  logic                 rco_q, rco_d;
  logic                 done_q, done_d;
  logic                 last_bit_s;
  logic                 word_end_s;

  // Next-state logic: sequencing, word reload on RCO and the two bit counters.
  always_comb begin
    state_d    = state_q;
    shreg_d    = shreg_q;
    bit_cnt_d  = bit_cnt_q;
    data_cnt_d = data_cnt_q;
    last_bit_s = (data_cnt_q == CNT_LAST);
    word_end_s = (bit_cnt_q == BIT_LAST);
    case (state_q)
      ST_IDLE: begin
        if (start) begin
          state_d    = ST_START;
          shreg_d    = data_in;
          bit_cnt_d  = BIT_ZERO;
          data_cnt_d = CNT_ZERO;
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_START: begin
        state_d = ST_DATA;
      end
      ST_DATA: begin
        if (last_bit_s) begin
          // The final bit ends the frame. data_in is ignored here, even on a word boundary.
          state_d    = ST_IDLE;
          bit_cnt_d  = BIT_ZERO;
          data_cnt_d = CNT_ZERO;
        end else begin
          data_cnt_d = data_cnt_q + CNT_ONE;
          if (word_end_s) begin
            // The next word replaces the shift when the current word's last bit leaves.
            bit_cnt_d = BIT_ZERO;
            shreg_d   = data_in;
          end else begin
            bit_cnt_d = bit_cnt_q + BIT_ONE;
            shreg_d   = shreg_q >> 1;
          end
        end
      end
      default: begin
        state_d    = ST_IDLE;
        shreg_d    = {WORD_SIZE{1'b0}};
        bit_cnt_d  = BIT_ZERO;
        data_cnt_d = CNT_ZERO;
      end
    endcase
  end

  // Output decode is taken from the next-state values, so each output is a flop of its own.
  always_comb begin
    data_out_d = IDLE_BIT;
    rco_d      = 1'b0;
    done_d     = 1'b0;
    case (state_d)
      ST_IDLE: begin
        data_out_d = IDLE_BIT;
      end
      ST_START: begin
        data_out_d = START_BIT;
      end
      ST_DATA: begin
        data_out_d = shreg_d[0];
        rco_d      = (bit_cnt_d == BIT_LAST);
        done_d     = (data_cnt_d == CNT_LAST);
      end
      default: begin
        data_out_d = IDLE_BIT;
      end
    endcase
  end

  // State and output registers. Reset aborts any frame at once and forces the idle line level.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q    <= ST_IDLE;
      shreg_q    <= {WORD_SIZE{1'b0}};
      bit_cnt_q  <= BIT_ZERO;
      data_cnt_q <= CNT_ZERO;
      data_out_q <= IDLE_BIT;
      rco_q      <= 1'b0;
      done_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      shreg_q    <= shreg_d;
      bit_cnt_q  <= bit_cnt_d;
      data_cnt_q <= data_cnt_d;
      data_out_q <= data_out_d;
      rco_q      <= rco_d;
      done_q     <= done_d;
    end
  end

  // busy is high through the whole frame. In idle it follows start directly, to acknowledge the request at once.
  always_comb begin
    if (state_q != ST_IDLE) begin
      busy = 1'b1;
    end else begin
      busy = start;
    end
  end

  assign data_out = data_out_q;
  assign RCO      = rco_q;
  assign done     = done_q;

endmodule

// File: tb/tb_serializer_with_counter.sv
// Directed bench for serializer_with_counter: default framing, a truncated frame,
// start while busy, back-to-back frames and reset mid-frame.
module tb_serializer_with_counter;

  logic       clock = 1'b0;
  logic       reset;
  logic       start, start2;
  logic [7:0] data_in, data_in2;
  logic       data_out, busy, rco, done;
  logic       data_out2, busy2, rco2, done2;
  int         n_tests = 0;
  int         n_fail  = 0;

  always #5 clock = ~clock;

  serializer_with_counter dut (
    .clock(clock), .reset(reset), .start(start), .data_in(data_in),
    .data_out(data_out), .busy(busy), .RCO(rco), .done(done)
  );

  serializer_with_counter #(.DATA_LENGTH(12), .WORD_SIZE(8)) dut_trunc (
    .clock(clock), .reset(reset), .start(start2), .data_in(data_in2),
    .data_out(data_out2), .busy(busy2), .RCO(rco2), .done(done2)
  );

  // Advance to 1 time unit after the next rising edge.
  task automatic next_cycle();
    @(posedge clock);
    #1;
  endtask

  task automatic test_reset();
    logic [3:0] got;
    reset = 1'b1; start = 1'b0; start2 = 1'b0; data_in = 8'h00; data_in2 = 8'h00;
    #2;
    got = {data_out, rco, done, busy};
    n_tests++;
    if (got !== 4'b1000) begin n_fail++; $display("FAIL reset_idle got=%b exp=1000", got); end
    got = {data_out2, rco2, done2, busy2};
    n_tests++;
    if (got !== 4'b1000) begin n_fail++; $display("FAIL reset_idle_trunc got=%b exp=1000", got); end
    start = 1'b1;
    next_cycle();
    got = {data_out, rco, done, busy};
    n_tests++;
    if (got !== 4'b1001) begin n_fail++; $display("FAIL reset_busy_follows_start got=%b exp=1001", got); end
    start = 1'b0;
    reset = 1'b0;
    next_cycle();
    got = {data_out, rco, done, busy};
    n_tests++;
    if (got !== 4'b1000) begin n_fail++; $display("FAIL post_reset_idle got=%b exp=1000", got); end
  endtask

  // Basic frame: A5 and then 3C. data_in carries junk outside the RCO cycle.
  task automatic test_basic();
    logic [15:0] frame;
    logic [3:0]  got, exp;
    frame = 16'h3CA5;
    start = 1'b1; data_in = 8'hA5;
    next_cycle();
    start = 1'b0;
    for (int c = 1; c <= 18; c++) begin
      if (c == 1)       exp = 4'b0001;
      else if (c <= 17) exp = {frame[c-2], (c == 9 || c == 17), (c == 17), 1'b1};
      else              exp = 4'b1000;
      got = {data_out, rco, done, busy};
      n_tests++;
      if (got !== exp) begin n_fail++; $display("FAIL basic cycle=%0d got=%b exp=%b", c, got, exp); end
      data_in = (c == 9) ? 8'h3C : 8'(c * 37 + 11);
      if (c < 18) next_cycle();
    end
  endtask

  // Start pulsed in cycle 5 is ignored: no restart and no second frame afterwards.
  task automatic test_start_while_busy();
    logic [15:0] frame;
    logic [3:0]  got, exp;
    frame = 16'h0F96;
    next_cycle();
    start = 1'b1; data_in = 8'h96;
    next_cycle();
    start = 1'b0;
    for (int c = 1; c <= 21; c++) begin
      if (c == 1)       exp = 4'b0001;
      else if (c <= 17) exp = {frame[c-2], (c == 9 || c == 17), (c == 17), 1'b1};
      else              exp = 4'b1000;
      got = {data_out, rco, done, busy};
      n_tests++;
      if (got !== exp) begin n_fail++; $display("FAIL start_while_busy cycle=%0d got=%b exp=%b", c, got, exp); end
      start   = (c == 5);
      data_in = (c == 9) ? 8'h0F : 8'hE7;
      if (c < 21) next_cycle();
    end
    start = 1'b0;
  endtask

  // start held high: the frames are separated by exactly one idle cycle (cycle 18).
  task automatic test_back_to_back();
    logic [15:0] f1, f2, frame;
    logic [3:0]  got, exp;
    int          cc;
    f1 = 16'h3CA5;
    f2 = 16'h8001;
    next_cycle();
    start = 1'b1; data_in = 8'hA5;
    next_cycle();
    for (int c = 1; c <= 36; c++) begin
      cc    = (c > 18) ? c - 18 : c;
      frame = (c > 18) ? f2 : f1;
      if (cc == 1)       exp = 4'b0001;
      else if (cc <= 17) exp = {frame[cc-2], (cc == 9 || cc == 17), (cc == 17), 1'b1};
      else               exp = {3'b100, start};
      got = {data_out, rco, done, busy};
      n_tests++;
      if (got !== exp) begin n_fail++; $display("FAIL back_to_back cycle=%0d got=%b exp=%b", c, got, exp); end
      if (c == 9)       data_in = 8'h3C;
      else if (c == 18) data_in = 8'h01;
      else if (c == 27) data_in = 8'h80;
      else              data_in = 8'h6B;
      if (c == 19) start = 1'b0;
      if (c < 36) next_cycle();
    end
  endtask

  // Reset in cycle 6 returns the line to idle at once; the next frame is complete and correct.
  task automatic test_reset_mid();
    logic [15:0] frame;
    logic [3:0]  got, exp;
    frame = 16'h5AC3;
    next_cycle();
    start = 1'b1; data_in = 8'hC3;
    next_cycle();
    start = 1'b0;
    for (int c = 1; c <= 6; c++) begin
      exp = (c == 1) ? 4'b0001 : {frame[c-2], 3'b001};
      got = {data_out, rco, done, busy};
      n_tests++;
      if (got !== exp) begin n_fail++; $display("FAIL reset_mid_pre cycle=%0d got=%b exp=%b", c, got, exp); end
      data_in = 8'h00;
      if (c < 6) next_cycle();
    end
    reset = 1'b1;
    #1;
    got = {data_out, rco, done, busy};
    n_tests++;
    if (got !== 4'b1000) begin n_fail++; $display("FAIL reset_mid_abort got=%b exp=1000", got); end
    next_cycle();
    reset = 1'b0;
    frame = 16'h815A;
    start = 1'b1; data_in = 8'h5A;
    next_cycle();
    start = 1'b0;
    for (int c = 1; c <= 18; c++) begin
      if (c == 1)       exp = 4'b0001;
      else if (c <= 17) exp = {frame[c-2], (c == 9 || c == 17), (c == 17), 1'b1};
      else              exp = 4'b1000;
      got = {data_out, rco, done, busy};
      n_tests++;
      if (got !== exp) begin n_fail++; $display("FAIL reset_mid_restart cycle=%0d got=%b exp=%b", c, got, exp); end
      data_in = (c == 9) ? 8'h81 : 8'h3E;
      if (c < 18) next_cycle();
    end
  endtask

  // DATA_LENGTH=12: eight 1s and then four 0s, RCO only in cycle 9, done in cycle 13.
  task automatic test_truncated();
    logic [3:0] got, exp;
    next_cycle();
    start2 = 1'b1; data_in2 = 8'hFF;
    next_cycle();
    start2 = 1'b0;
    for (int c = 1; c <= 15; c++) begin
      if (c == 1)       exp = 4'b0001;
      else if (c <= 13) exp = {(c <= 9), (c == 9), (c == 13), 1'b1};
      else              exp = 4'b1000;
      got = {data_out2, rco2, done2, busy2};
      n_tests++;
      if (got !== exp) begin n_fail++; $display("FAIL truncated cycle=%0d got=%b exp=%b", c, got, exp); end
      data_in2 = (c == 9) ? 8'h00 : 8'hF0;
      if (c < 15) next_cycle();
    end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_start_while_busy();
    test_back_to_back();
    test_reset_mid();
    test_truncated();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/serializer_with_counter.md
SERIALIZER_WITH_COUNTER -- requirements
Module: serializer_with_counter

Interface
REQ-001 The block SHALL have parameter DATA_LENGTH, default 16, giving the serial bits per frame, excluding the start bit.
REQ-002 The block SHALL have parameter WORD_SIZE, default 8, giving the parallel word width.
REQ-003 The block SHALL have parameter START_BIT, default 1'b0, giving the level driven for one bit-time before the data bits.
REQ-004 The block SHALL have parameter IDLE_BIT, default 1'b1, giving the line level outside a frame.
REQ-005 The block SHALL have port clock, input, 1 bit: the single clock; all state changes on its rising edge.
REQ-006 The block SHALL have port reset, input, 1 bit: asynchronous, active-high reset.
REQ-007 The block SHALL have port start, input, 1 bit: frame request, sampled only in IDLE.
REQ-008 The block SHALL have port data_in, input, WORD_SIZE bits: parallel word to transmit.
REQ-009 The block SHALL have port data_out, output, 1 bit: serial line.
REQ-010 The block SHALL have port busy, output, 1 bit: frame in progress.
REQ-011 The block SHALL have port RCO, output, 1 bit: last bit of the current word is on the line, and the next word must be present on data_in.
REQ-012 The block SHALL have port done, output, 1 bit: last data bit of the frame is on the line.

Function
REQ-013 The block SHALL implement three states: IDLE, START, DATA.
REQ-014 In IDLE with start=1 at a rising edge, the block SHALL load data_in into the shift register, clear both counters, and enter START.
REQ-015 In IDLE with start=0, the block SHALL remain in IDLE.
REQ-016 START SHALL last exactly one cycle with data_out=START_BIT, then enter DATA.
REQ-017 In DATA, data_out SHALL equal shift register bit 0, and the shift register SHALL shift right by one each cycle, LSB first.
REQ-018 The word bit counter SHALL count 0..WORD_SIZE-1 and wrap to 0.
REQ-019 The data counter SHALL count 0..DATA_LENGTH-1 and SHALL be wide enough that it never wraps within a frame.
REQ-020 RCO SHALL be 1 in every DATA cycle whose word bit counter equals WORD_SIZE-1, including the final word when DATA_LENGTH is a multiple of WORD_SIZE, and 0 otherwise.
REQ-021 At the edge ending an RCO cycle that is not the final data bit, the block SHALL load data_in into the shift register in place of the shift.
REQ-022 At the edge ending the final data bit, data_in SHALL be ignored.
REQ-023 done SHALL be 1 exactly in the DATA cycle whose data counter equals DATA_LENGTH-1.
REQ-024 From that final data-bit cycle, the block SHALL enter IDLE on the next edge.
REQ-025 When DATA_LENGTH is not a multiple of WORD_SIZE, the block SHALL truncate the final word after its low (DATA_LENGTH mod WORD_SIZE) bits and SHALL NOT assert RCO for it.
REQ-026 Frame timing, with start sampled at edge 0: cycle 1 SHALL carry the start bit, cycles 2..DATA_LENGTH+1 SHALL carry the data bits, and cycle DATA_LENGTH+2 SHALL be IDLE.
REQ-027 busy SHALL be 1 in START and DATA, and SHALL also be 1 combinationally in IDLE while start=1.
REQ-028 In IDLE, data_out SHALL be IDLE_BIT, and RCO and done SHALL be 0.
REQ-029 Assertion of start while not in IDLE SHALL be ignored, with no restart and no queuing.
REQ-030 If start=1 is held continuously, a new frame SHALL begin at the first edge in IDLE, giving exactly one IDLE cycle between frames.
REQ-031 data_out, RCO and done SHALL be decoded from registers only, with no combinational path from start or data_in.

Reset
REQ-032 While reset=1, asynchronously, the block SHALL be in IDLE, the shift register and both counters SHALL be 0, data_out SHALL be IDLE_BIT, and RCO, done and busy SHALL be 0, except that busy follows start per REQ-027.
REQ-033 Reset asserted mid-frame SHALL abort the frame immediately, with data_out returning to IDLE_BIT in the same cycle; no partial-frame resume SHALL occur.
REQ-034 After reset deasserts, the block SHALL accept start at the first rising edge.

Verification
REQ-035 Basic frame (defaults): data_in=0xA5 at start; data_in=0x3C during the first RCO -> data_out over cycles 1..17 = 0, then 1,0,1,0,0,1,0,1, then 0,0,1,1,1,1,0,0; RCO=1 in cycles 9 and 17; done=1 only in cycle 17; data_out=1 and busy=0 in cycle 18.
REQ-036 Start while busy: pulse start in cycle 5 of a frame -> frame unchanged, and no second frame begins after cycle 17.
REQ-037 Back-to-back frames: hold start=1 continuously -> start bits occur in cycle 1 and cycle 19, with exactly one IDLE cycle (cycle 18) between them.
REQ-038 Reset mid-frame: assert reset in cycle 6 -> data_out=1 and busy=0 in that cycle; a new start after release produces a complete, correct frame.
REQ-039 Truncated frame: DATA_LENGTH=12, WORD_SIZE=8, words 0xFF then 0x00 -> data bits are eight 1s then four 0s; RCO=1 only in cycle 9; done=1 in cycle 13.
REQ-040 data_in changes in non-RCO cycles -> the transmitted bits are unaffected.
